// File: rtl/simple_axi_pkg.sv
// Shared types for the single-beat AXI4 memory responder: response codes,
// write/read FSM states and the fixed data-path widths.
package simple_axi_pkg;

  localparam int AXI_DATA_W = 64;
  localparam int AXI_STRB_W = 8;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_t;

  // Decode error outranks slave error.
  function automatic resp_t pick_resp(input logic dec, input logic slv);
    return dec ? RESP_DECERR : (slv ? RESP_SLVERR : RESP_OKAY);
  endfunction

endpackage

// File: rtl/simple_axi_slave_ram.sv
// Word-organised scratch RAM: one byte-strobed write port and one registered
// read port. A read and a write to the same word in one cycle return old data.
module simple_axi_slave_ram
  import simple_axi_pkg::*;
#(
  parameter int WORDS = 16,
  parameter int IW    = 4
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [IW-1:0]         waddr_i,
  input  logic [AXI_DATA_W-1:0] wdata_i,
  input  logic [AXI_STRB_W-1:0] wstrb_i,
  input  logic                  re_i,
  input  logic [IW-1:0]         raddr_i,
  output logic [AXI_DATA_W-1:0] rdata_o
);

  logic [AXI_DATA_W-1:0] mem_q [WORDS];
  logic [AXI_DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
    if (we_i) begin
      for (int k = 0; k < AXI_STRB_W; k++) begin
        if (wstrb_i[k]) mem_q[waddr_i][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/simple_axi_slave.sv
// Single-beat AXI4 memory responder with programmable wait states.
// Define SIMPLE_AXI_SLAVE_RO_EN to make [RO_BASE, MEM_BYTES) write-protected.
module simple_axi_slave
  import simple_axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_BYTES  = 128,
  parameter int RO_BASE    = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [7:0]            i_wait,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [2:0]            s_axi_awsize,
  input  logic [7:0]            s_axi_awlen,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  input  logic [AXI_DATA_W-1:0] s_axi_wdata,
  input  logic [AXI_STRB_W-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  output logic [1:0]            s_axi_bresp,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [2:0]            s_axi_arsize,
  input  logic [7:0]            s_axi_arlen,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [AXI_DATA_W-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; once raised, valid and its payload hold until that edge.
  localparam int WORDS = MEM_BYTES / 8;
  localparam int IW    = $clog2(WORDS);
  localparam logic [ADDR_WIDTH-1:0] MEM_LIMIT = ADDR_WIDTH'(MEM_BYTES);
  localparam logic [ADDR_WIDTH-1:0] RO_LIMIT  = ADDR_WIDTH'(RO_BASE);
`ifdef SIMPLE_AXI_SLAVE_RO_EN
  localparam bit RO_EN = 1'b1;
`else
  localparam bit RO_EN = 1'b0;
`endif

  wr_state_t             wr_state_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [2:0]            wsize_q;
  logic [7:0]            wlen_q, wwait_q, wcnt_q;
  logic                  awready_q, wready_q, bvalid_q;
  resp_t                 bresp_q, w_resp_d;

  rd_state_t             rd_state_q;
  logic [IW-1:0]         raddr_q, ram_raddr;
  logic [7:0]            rcnt_q;
  logic                  arready_q, rvalid_q;
  resp_t                 rresp_q, r_resp_d;

  logic                  ram_we, ram_re;
  logic [AXI_DATA_W-1:0] ram_rdata;

  always_comb begin
    w_resp_d  = pick_resp(waddr_q >= MEM_LIMIT,
                          (wsize_q > 3'd3) || (wlen_q != 8'd0) || !s_axi_wlast ||
                          (RO_EN && (waddr_q >= RO_LIMIT)));
    r_resp_d  = pick_resp(s_axi_araddr >= MEM_LIMIT,
                          (s_axi_arsize > 3'd3) || (s_axi_arlen != 8'd0));
    ram_we    = (wr_state_q == W_DATA) && s_axi_wvalid && (w_resp_d == RESP_OKAY);
    // With zero wait states the RAM is read directly on the AR handshake edge.
    ram_re    = ((rd_state_q == R_IDLE) && s_axi_arvalid && (i_wait == 8'd0)) ||
                ((rd_state_q == R_WAIT) && (rcnt_q == 8'd0));
    ram_raddr = (rd_state_q == R_IDLE) ? s_axi_araddr[IW+2:3] : raddr_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b1;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      waddr_q    <= '0;
      wsize_q    <= '0;
      wlen_q     <= '0;
      wwait_q    <= '0;
      wcnt_q     <= '0;
    end else begin
      case (wr_state_q)
        W_IDLE: if (s_axi_awvalid) begin
          waddr_q    <= s_axi_awaddr;
          wsize_q    <= s_axi_awsize;
          wlen_q     <= s_axi_awlen;
          wwait_q    <= i_wait;
          awready_q  <= 1'b0;
          wready_q   <= 1'b1;
          wr_state_q <= W_DATA;
        end
        W_DATA: if (s_axi_wvalid) begin
          wready_q <= 1'b0;
          bresp_q  <= w_resp_d;
          if (wwait_q == 8'd0) begin
            bvalid_q   <= 1'b1;
            wr_state_q <= W_RESP;
          end else begin
            wcnt_q     <= wwait_q - 8'd1;
            wr_state_q <= W_WAIT;
          end
        end
        W_WAIT: if (wcnt_q == 8'd0) begin
          bvalid_q   <= 1'b1;
          wr_state_q <= W_RESP;
        end else begin
          wcnt_q <= wcnt_q - 8'd1;
        end
        W_RESP: if (s_axi_bready) begin
          bvalid_q   <= 1'b0;
          awready_q  <= 1'b1;
          wr_state_q <= W_IDLE;
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b1;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      raddr_q    <= '0;
      rcnt_q     <= '0;
    end else begin
      case (rd_state_q)
        R_IDLE: if (s_axi_arvalid) begin
          raddr_q   <= s_axi_araddr[IW+2:3];
          rresp_q   <= r_resp_d;
          arready_q <= 1'b0;
          if (i_wait == 8'd0) begin
            rvalid_q   <= 1'b1;
            rd_state_q <= R_DATA;
          end else begin
            rcnt_q     <= i_wait - 8'd1;
            rd_state_q <= R_WAIT;
          end
        end
        R_WAIT: if (rcnt_q == 8'd0) begin
          rvalid_q   <= 1'b1;
          rd_state_q <= R_DATA;
        end else begin
          rcnt_q <= rcnt_q - 8'd1;
        end
        R_DATA: if (s_axi_rready) begin
          rvalid_q   <= 1'b0;
          arready_q  <= 1'b1;
          rd_state_q <= R_IDLE;
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  simple_axi_slave_ram #(.WORDS(WORDS), .IW(IW)) u_ram (
    .clk_i   (i_clk),
    .we_i    (ram_we),
    .waddr_i (waddr_q[IW+2:3]),
    .wdata_i (s_axi_wdata),
    .wstrb_i (s_axi_wstrb),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rlast   = rvalid_q;
  // The RAM output register is held across the wait; errors and idle show zero.
  assign s_axi_rdata   = (rvalid_q && (rresp_q == RESP_OKAY)) ? ram_rdata : '0;

endmodule
